ro_measure_sequencer: RTL and testbench

//  Sequences frequency measurements of NUM_RO ring oscillators that share one async up-counter.
//  For each measurement it:
//   - clears the counter;
//   - enables one RO for a programmed gate window of reference-clock cycles;
//   - disables the RO and waits for the ripple counter to settle;
//   - captures the count and presents it to the readout logic on a valid/ready handshake.

---
 rtl/ro_seq_pkg.sv | 24 ++
 rtl/ro_seq_timer.sv | 27 ++
 rtl/ro_measure_sequencer.sv | 179 +++++++++++++++++
 tb/tb_ro_measure_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_seq_pkg.sv
// Shared types, default widths and helpers for the ring-oscillator measurement sequencer.
package ro_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

    localparam int unsigned DEF_NUM_RO        = 8;
    localparam int unsigned DEF_GATE_W        = 16;
    localparam int unsigned DEF_CNT_W         = 16;
    localparam int unsigned DEF_CLR_CYCLES    = 2;
    localparam int unsigned DEF_SETTLE_CYCLES = 4;

    // Channel index width; at least one bit.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ro_seq_timer.sv
// Loadable down-counter shared by the CLEAR, GATE and SETTLE phases; saturates at zero.
module ro_seq_timer #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/ro_measure_sequencer.sv
// Sequences clear / gate / settle / capture of NUM_RO ring oscillators sharing one counter.
// Optional feature: RO_SEQ_AUTO_SCAN_EN enables round-robin scanning driven by i_scan_en.
module ro_measure_sequencer
    import ro_seq_pkg::*;
#(
    parameter  int unsigned NUM_RO        = DEF_NUM_RO,
    parameter  int unsigned GATE_W        = DEF_GATE_W,
    parameter  int unsigned CNT_W         = DEF_CNT_W,
    parameter  int unsigned CLR_CYCLES    = DEF_CLR_CYCLES,
    parameter  int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    localparam int unsigned CH_W          = ch_w(NUM_RO)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [CH_W-1:0]   i_ch_sel,
    input  logic [GATE_W-1:0] i_gate_cycles,
    input  logic              i_scan_en,
    output logic              o_busy,
    output logic [NUM_RO-1:0] o_ro_en,
    output logic              o_cnt_clr,
    input  logic [CNT_W-1:0]  i_cnt_in,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [CNT_W-1:0]  o_res_count,
    output logic [CH_W-1:0]   o_res_ch
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_ch;
    logic [GATE_W-1:0]   r_gate;
    logic [CNT_W-1:0]    r_res_count;
    logic [CH_W-1:0]     r_res_ch;

    logic                w_tmr_load;
    logic [GATE_W-1:0]   w_tmr_val;
    logic                w_tmr_en;
    logic                w_tmr_zero;
    logic                w_accept;
    logic                w_scan_step;
    logic                w_capture;
    logic                w_ch_valid;
    logic [CH_W-1:0]     w_ch_next;
    logic [GATE_W-1:0]   w_gate_last;

    assign w_ch_valid  = (32'(i_ch_sel) < NUM_RO);
    assign w_ch_next   = (r_ch == CH_W'(NUM_RO - 1)) ? '0 : r_ch + CH_W'(1);
    // A zero gate length still opens the window for one cycle.
    assign w_gate_last = (r_gate == '0) ? '0 : r_gate - GATE_W'(1);

`ifndef RO_SEQ_AUTO_SCAN_EN
    logic w_unused_scan;
    assign w_unused_scan = i_scan_en;
`endif

    ro_seq_timer #(
        .W (GATE_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero_c   (w_tmr_zero)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and timer control; each timed phase loads length-1.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_tmr_en    = 1'b0;
        w_accept    = 1'b0;
        w_scan_step = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && w_ch_valid) begin
                    w_accept    = 1'b1;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = GATE_W'(CLR_CYCLES - 1);
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (w_tmr_zero) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = w_gate_last;
                    w_state_nxt = GATE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            GATE: begin
                if (w_tmr_zero) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = GATE_W'(SETTLE_CYCLES - 1);
                    w_state_nxt = SETTLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            SETTLE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = CAPTURE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (i_res_ready) begin
`ifdef RO_SEQ_AUTO_SCAN_EN
                    if (i_scan_en) begin
                        w_scan_step = 1'b1;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = GATE_W'(CLR_CYCLES - 1);
                        w_state_nxt = CLEAR;
                    end else begin
                        w_state_nxt = IDLE;
                    end
`else
                    w_state_nxt = IDLE;
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Measurement context and captured result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ch        <= '0;
            r_gate      <= '0;
            r_res_count <= '0;
            r_res_ch    <= '0;
        end else begin
            if (w_accept) begin
                r_ch   <= i_ch_sel;
                r_gate <= i_gate_cycles;
            end else if (w_scan_step) begin
                r_ch   <= w_ch_next;
                r_gate <= i_gate_cycles;
            end
            if (w_capture) begin
                r_res_count <= i_cnt_in;
                r_res_ch    <= r_ch;
            end
        end
    end

    // Moore output decode.
    always_comb begin
        o_busy      = (r_state != IDLE);
        o_ro_en     = '0;
        o_cnt_clr   = (r_state == CLEAR);
        o_res_valid = (r_state == HOLD);
        o_res_count = r_res_count;
        o_res_ch    = r_res_ch;
        if (r_state == GATE) begin
            o_ro_en = NUM_RO'(1) << r_ch;
        end
    end

endmodule

// File: tb/tb_ro_measure_sequencer.sv
// Self-checking bench for ro_measure_sequencer: directed table, corner sequences and random runs.
module tb_ro_measure_sequencer;

    localparam int CLR    = 2;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [2:0]  i_ch_sel;
    logic [15:0] i_gate_cycles;
    logic        i_scan_en;
    logic        o_busy;
    logic [7:0]  o_ro_en;
    logic        o_cnt_clr;
    logic [15:0] tb_cnt;
    logic        o_res_valid;
    logic        i_res_ready;
    logic [15:0] o_res_count;
    logic [2:0]  o_res_ch;

    // Second instance with a non power-of-two channel count for out-of-range selects.
    logic        s6_start;
    logic [2:0]  s6_ch;
    logic        o6_busy;
    logic [5:0]  o6_ro_en;
    logic        o6_cnt_clr;
    logic        o6_res_valid;
    logic [15:0] o6_res_count;
    logic [2:0]  o6_res_ch;

    int tb_rate = 1;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ro_measure_sequencer u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (i_start),
        .i_ch_sel      (i_ch_sel),
        .i_gate_cycles (i_gate_cycles),
        .i_scan_en     (i_scan_en),
        .o_busy        (o_busy),
        .o_ro_en       (o_ro_en),
        .o_cnt_clr     (o_cnt_clr),
        .i_cnt_in      (tb_cnt),
        .o_res_valid   (o_res_valid),
        .i_res_ready   (i_res_ready),
        .o_res_count   (o_res_count),
        .o_res_ch      (o_res_ch)
    );

    ro_measure_sequencer #(.NUM_RO(6)) u_dut6 (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (s6_start),
        .i_ch_sel      (s6_ch),
        .i_gate_cycles (16'd1),
        .i_scan_en     (1'b0),
        .o_busy        (o6_busy),
        .o_ro_en       (o6_ro_en),
        .o_cnt_clr     (o6_cnt_clr),
        .i_cnt_in      (16'd0),
        .o_res_valid   (o6_res_valid),
        .i_res_ready   (1'b1),
        .o_res_count   (o6_res_count),
        .o_res_ch      (o6_res_ch)
    );

    // Shared-counter model: cleared by cnt_clr, +rate per enabled cycle, drifts while idle.
    always @(posedge clk) begin
        if (rst || o_cnt_clr) tb_cnt <= 16'd0;
        else if (o_ro_en != 8'h00) tb_cnt <= tb_cnt + 16'(tb_rate);
        else if (!o_busy) tb_cnt <= tb_cnt + 16'd3;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full measurement; expectations derived from the phase lengths alone.
    task automatic measure(input int ch, input int gate, input int rate, input int hold_wait,
                           input logic [15:0] exp_cnt, input string tag);
        int g_eff, lat, bad;
        logic [7:0]  exp_ro;
        logic [15:0] held_cnt;
        logic [2:0]  held_ch;
        g_eff  = (gate == 0) ? 1 : gate;
        lat    = CLR + g_eff + SETTLE + 1;
        exp_ro = 8'(1) << ch;
        tb_rate       = rate;
        i_ch_sel      = 3'(ch);
        i_gate_cycles = 16'(gate);
        i_start       = 1'b1;
        tick();
        bad = 0;
        for (int k = 0; k < lat; k++) begin
            if (o_busy !== 1'b1) bad++;
            if (o_res_valid !== 1'b0) bad++;
            if (o_cnt_clr !== (k < CLR)) bad++;
            if (o_ro_en !== ((k >= CLR && k < CLR + g_eff) ? exp_ro : 8'h00)) bad++;
            i_start       = 1'($urandom_range(0, 1));
            i_ch_sel      = 3'($urandom);
            i_gate_cycles = 16'($urandom);
            tick();
        end
        i_start = 1'b0;
        check({tag, "_valid_at_latency"}, 32'(o_res_valid), 32'd1);
        check({tag, "_res_count"}, 32'(o_res_count), 32'(exp_cnt));
        check({tag, "_res_ch"}, 32'(o_res_ch), 32'(ch));
        held_cnt = o_res_count;
        held_ch  = o_res_ch;
        for (int h = 0; h < hold_wait; h++) begin
            i_res_ready = 1'b0;
            i_start     = 1'($urandom_range(0, 1));
            tick();
            if (o_res_valid !== 1'b1 || o_res_count !== held_cnt || o_res_ch !== held_ch ||
                o_ro_en !== 8'h00 || o_busy !== 1'b1) bad++;
        end
        check({tag, "_timeline_bad_cycles"}, 32'(bad), 32'd0);
        i_res_ready = 1'b1;
        i_start     = 1'b1;
        tick();
        i_res_ready = 1'b0;
        i_start     = 1'b0;
        check({tag, "_idle_after_handshake"}, 32'(o_busy), 32'd0);
        check({tag, "_valid_drop"}, 32'(o_res_valid), 32'd0);
        tick();
    endtask

    typedef struct {
        int          ch;
        int          gate;
        int          rate;
        int          hold;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n, ch, g, r, h, valid_seen;
        logic [2:0] scan_got[4];

        vecs[0] = '{3, 10, 1, 5, 16'd10};
        vecs[1] = '{0, 0, 1, 0, 16'd1};
        vecs[2] = '{7, 1, 2, 1, 16'd2};
        vecs[3] = '{2, 300, 300, 1, 16'd24464};
        vecs[4] = '{5, 17, 1000, 2, 16'd17000};

        rst = 1'b1;
        i_start = 1'b0; i_ch_sel = '0; i_gate_cycles = '0; i_scan_en = 1'b0; i_res_ready = 1'b0;
        s6_start = 1'b0; s6_ch = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ro_en", 32'(o_ro_en), 32'd0);
        check("rst_cnt_clr", 32'(o_cnt_clr), 32'd0);
        check("rst_res_valid", 32'(o_res_valid), 32'd0);
        check("rst_res_count", 32'(o_res_count), 32'd0);
        check("rst_res_ch", 32'(o_res_ch), 32'd0);

        for (int v = 0; v < 5; v++) begin
            measure(vecs[v].ch, vecs[v].gate, vecs[v].rate, vecs[v].hold, vecs[v].exp_cnt,
                    $sformatf("vec%0d", v));
        end

        // Out-of-range channel on the 6-channel instance is ignored.
        s6_ch = 3'd6; s6_start = 1'b1; tick();
        check("ch6_ignored_busy", 32'(o6_busy), 32'd0);
        s6_ch = 3'd7; tick();
        check("ch7_ignored_busy", 32'(o6_busy), 32'd0);
        s6_ch = 3'd5; tick();
        s6_start = 1'b0;
        check("ch5_accepted_busy", 32'(o6_busy), 32'd1);
        tick(); tick();
        check("ch5_ro_en", 32'(o6_ro_en), 32'h20);
        repeat (10) tick();
        check("dut6_back_idle", 32'(o6_busy), 32'd0);

        // Reset in the middle of the gate window.
        tb_rate = 1;
        i_ch_sel = 3'd4; i_gate_cycles = 16'd20; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (4) tick();
        check("midgate_ro_en", 32'(o_ro_en), 32'h10);
        rst = 1'b1;
        tick();
        check("midgate_rst_ro_en", 32'(o_ro_en), 32'd0);
        check("midgate_rst_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        valid_seen = 0;
        i_res_ready = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (o_res_valid === 1'b1 || o_busy === 1'b1) valid_seen++;
        end
        check("midgate_no_result", 32'(valid_seen), 32'd0);
        check("midgate_res_count_cleared", 32'(o_res_count), 32'd0);

`ifdef RO_SEQ_AUTO_SCAN_EN
        // Round-robin from channel 6 with wrap; dropping scan_en ends after the current result.
        tb_rate = 1;
        i_scan_en = 1'b1; i_res_ready = 1'b1;
        i_ch_sel = 3'd6; i_gate_cycles = 16'd3; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int s = 0; s < 4; s++) begin
            n = 0;
            while (o_res_valid !== 1'b1 && n < 100) begin
                tick();
                n++;
            end
            check($sformatf("scan_wait%0d", s), 32'(o_res_valid), 32'd1);
            scan_got[s] = o_res_ch;
            if (s == 3) i_scan_en = 1'b0;
            tick();
        end
        check("scan_ch0", 32'(scan_got[0]), 32'd6);
        check("scan_ch1", 32'(scan_got[1]), 32'd7);
        check("scan_ch2", 32'(scan_got[2]), 32'd0);
        check("scan_ch3", 32'(scan_got[3]), 32'd1);
        check("scan_stopped", 32'(o_busy), 32'd0);
        i_res_ready = 1'b0;
        tick();
`else
        scan_got[0] = 3'd0;
        i_scan_en = 1'b1;
        measure(1, 4, 7, 0, 16'd28, "scan_ignored");
        i_scan_en = 1'b0;
`endif

        // Random measurements against the arithmetic model.
        for (int t = 0; t < 20; t++) begin
            ch = int'($urandom_range(0, 7));
            g  = int'($urandom_range(0, 40));
            r  = int'($urandom_range(1, 5000));
            h  = int'($urandom_range(0, 3));
`ifndef RO_SEQ_AUTO_SCAN_EN
            i_scan_en = 1'($urandom_range(0, 1));
`endif
            measure(ch, g, r, h, 16'(((g == 0) ? 1 : g) * r), $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
